// File: rtl/arb_bus_pkg.sv
// Shared types and helpers for the arbiter-driven burst writer.
//   NUM_M         number of requesting masters
//   state_t       burst controller states
//   onehot_valid  true when exactly one bit of a grant vector is set
package arb_bus_pkg;

  localparam int unsigned NUM_M = 4;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_XFER = 3'd1;
  localparam logic [ST_W-1:0] ST_DONE = 3'd2;
  localparam logic [ST_W-1:0] ST_ABRT = 3'd3;
  localparam logic [ST_W-1:0] ST_REL  = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = ST_IDLE,
    S_XFER = ST_XFER,
    S_DONE = ST_DONE,
    S_ABRT = ST_ABRT,
    S_REL  = ST_REL
  } state_t;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  function automatic logic onehot_valid(input logic [NUM_M-1:0] v);
    return (v != '0) && ((v & (v - NUM_M'(1))) == '0);
  endfunction

endpackage

// File: rtl/arb_bus_xfer_onehot_enc4.sv
// One-hot to binary encoder for the 4-way grant.
//   onehot  in   4-bit grant vector
//   idx_c   out  binary index of the set bit (meaningful only when vld_c)
//   vld_c   out  exactly one bit of onehot is set
module onehot_enc4
  import arb_bus_pkg::*;
(
  input  logic [3:0] onehot,
  output logic [1:0] idx_c,
  output logic       vld_c
);

  assign idx_c = {onehot[3] | onehot[2], onehot[3] | onehot[1]};
  assign vld_c = onehot_valid(onehot);

endmodule

// File: rtl/arb_bus_xfer.sv
// Burst writer driven by a 4-way arbiter grant. Captures the granted master's
// base address and length, streams its write data onto a valid/ready target
// bus, then reports done or abort to that master.
//   clk, rst    clock, synchronous active-high reset
//   gnt         one-hot grant (0 = none, multi-bit ignored)
//   m_addr      per-master base address, master i at [i*AW +: AW]
//   m_wdata     per-master write data, master i at [i*DW +: DW]
//   m_len       per-master burst length minus one, master i at [i*LW +: LW]
//   bus_valid   beat offered; bus_ready accepts it
//   bus_addr    base + beat index (wraps at 2^AW)
//   bus_wdata   owner's live write data
//   bus_last    final beat marker
//   done/abort  one-cycle per-master completion / grant-loss pulses
//   busy        controller not idle
module arb_bus_xfer
  import arb_bus_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16,
  parameter int unsigned LW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    gnt,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_wdata,
  input  logic [NUM_M*LW-1:0] m_len,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [AW-1:0]       bus_addr,
  output logic [DW-1:0]       bus_wdata,
  output logic                bus_last,
  output logic [NUM_M-1:0]    done,
  output logic [NUM_M-1:0]    abort,
  output logic                busy
);

  state_t           state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [AW-1:0]    base, base_nxt;
  logic [LW-1:0]    len, len_nxt;
  logic [LW-1:0]    beat, beat_nxt;
  logic [1:0]       cap_idx;
  logic             cap_vld;
  logic [NUM_M-1:0] owner_oh;

  onehot_enc4 u_enc (
    .onehot (gnt),
    .idx_c  (cap_idx),
    .vld_c  (cap_vld)
  );

  // State and burst context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= '0;
      base  <= '0;
      len   <= '0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      base  <= base_nxt;
      len   <= len_nxt;
      beat  <= beat_nxt;
    end
  end

  assign owner_oh  = NUM_M'(1) << owner;
  assign bus_addr  = base + AW'(beat);
  assign bus_wdata = m_wdata[32'(owner)*DW +: DW];
  assign busy      = (state != S_IDLE);

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    base_nxt  = base;
    len_nxt   = len;
    beat_nxt  = beat;
    bus_valid = 1'b0;
    bus_last  = 1'b0;
    done      = '0;
    abort     = '0;

    case (state)
      S_IDLE: begin
        if (cap_vld) begin
          owner_nxt = cap_idx;
          base_nxt  = m_addr[32'(cap_idx)*AW +: AW];
          len_nxt   = m_len[32'(cap_idx)*LW +: LW];
          beat_nxt  = '0;
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        bus_valid = 1'b1;
        bus_last  = (beat == len);
        // Grant loss wins over a same-cycle handshake; that beat is not counted.
        if (!gnt[owner]) begin
          state_nxt = S_ABRT;
        end else if (bus_ready) begin
          if (beat == len) begin
            state_nxt = S_DONE;
          end else begin
            beat_nxt = beat + LW'(1);
          end
        end
      end
      S_DONE: begin
        done      = owner_oh;
        state_nxt = S_REL;
      end
      S_ABRT: begin
        abort     = owner_oh;
        state_nxt = S_REL;
      end
      S_REL: begin
        // Hold off until the arbiter drops the stale grant.
        if (gnt == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_arb_bus_xfer.sv
module tb_arb_bus_xfer;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 4;

  logic              clk;
  logic              rst;
  logic [3:0]        gnt;
  logic [4*AW-1:0]   m_addr;
  logic [4*DW-1:0]   m_wdata;
  logic [4*LW-1:0]   m_len;
  logic              bus_valid;
  logic              bus_ready;
  logic [AW-1:0]     bus_addr;
  logic [DW-1:0]     bus_wdata;
  logic              bus_last;
  logic [3:0]        done;
  logic [3:0]        abort;
  logic              busy;

  arb_bus_xfer #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .gnt       (gnt),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_len     (m_len),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_last  (bus_last),
    .done      (done),
    .abort     (abort),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t      exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         done_cnt, abort_cnt, pops, valid_cnt;
  logic [3:0] done_acc, abort_acc, owner_bit;
  bit         tog;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    beat_t e;
    e.a = a; e.d = d; e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic set_m(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    m_addr[i*AW +: AW] = a;
    m_len[i*LW +: LW]  = l;
  endtask

  task automatic clr();
    done_cnt = 0; abort_cnt = 0; pops = 0; valid_cnt = 0;
    done_acc = '0; abort_acc = '0;
  endtask

  // Observe the cycle before its edge, then advance one clock.
  // A handshake only counts while the owner still holds its grant.
  task automatic cycle();
    beat_t e;
    if (bus_valid) valid_cnt++;
    if (bus_valid && bus_ready && ((gnt & owner_bit) != 4'b0)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL extra_beat observed_addr=%0h expected=no beat", bus_addr);
      end else begin
        e = exp_q.pop_front();
        pops++;
        chk("beat_addr", 32'(bus_addr), 32'(e.a));
        chk("beat_wdata", 32'(bus_wdata), 32'(e.d));
        chk("beat_last", 32'(bus_last), 32'(e.l));
      end
    end
    if (done != 4'b0) begin done_cnt++; done_acc |= done; end
    if (abort != 4'b0) begin abort_cnt++; abort_acc |= abort; end
    @(posedge clk);
    #1;
    if (tog) bus_ready = ~bus_ready;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; gnt = 4'b0; bus_ready = 1'b0; tog = 1'b0; owner_bit = 4'b0;
    m_addr = '0; m_len = '0;
    m_wdata = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
    clr();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", 32'(bus_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_last", 32'(bus_last), 0);

    // Master 0: three-beat burst at 0x10, target always ready.
    set_m(0, 8'h10, 4'd2);
    push(8'h10, 16'hA000, 1'b0); push(8'h11, 16'hA000, 1'b0); push(8'h12, 16'hA000, 1'b1);
    owner_bit = 4'b0001; bus_ready = 1'b1; gnt = 4'b0001;
    chk("t1_no_valid_on_gnt", 32'(bus_valid), 0);
    cycle();
    chk("t1_first_valid", 32'(bus_valid), 1);
    chk("t1_first_addr", 32'(bus_addr), 32'h10);
    clr();
    run(3);
    chk("t1_done_pulse", 32'(done), 32'h1);
    chk("t1_beats", 32'(pops), 3);
    gnt = 4'b0;
    cycle();
    chk("t1_done_one_cycle", 32'(done), 0);
    cycle();
    chk("t1_idle", 32'(busy), 0);

    // Master 1: two beats with ready toggling 1,0,1,0.
    set_m(1, 8'h40, 4'd1);
    push(8'h40, 16'hB111, 1'b0); push(8'h41, 16'hB111, 1'b1);
    owner_bit = 4'b0010; bus_ready = 1'b1; gnt = 4'b0010;
    cycle();
    clr();
    tog = 1'b1;
    run(1);
    chk("t2_hold_ready", 32'(bus_ready), 0);
    chk("t2_hold_valid", 32'(bus_valid), 1);
    chk("t2_hold_addr", 32'(bus_addr), 32'h41);
    chk("t2_hold_last", 32'(bus_last), 1);
    run(1);
    chk("t2_still_held", 32'(bus_addr), 32'h41);
    run(1);
    // Grant stays high after done: no replay while it lingers.
    tog = 1'b0; bus_ready = 1'b1;
    clr();
    run(5);
    chk("t2_done_once", 32'(done_cnt), 1);
    chk("t2_done_owner", 32'(done_acc), 32'h2);
    chk("t2_no_replay", 32'(valid_cnt), 0);
    chk("t2_rel_busy", 32'(busy), 1);
    chk("t2_queue_empty", 32'(exp_q.size()), 0);
    gnt = 4'b0;
    run(2);
    chk("t2_released", 32'(busy), 0);
    push(8'h40, 16'hB111, 1'b0); push(8'h41, 16'hB111, 1'b1);
    gnt = 4'b0010;
    cycle();
    chk("t5_new_burst", 32'(bus_valid), 1);
    clr();
    run(3);
    chk("t5_done", 32'(done_cnt), 1);
    chk("t5_beats", 32'(pops), 2);
    gnt = 4'b0;
    run(2);

    // Master 3: address wrap 0xFE..0x01.
    set_m(3, 8'hFE, 4'd3);
    push(8'hFE, 16'hD333, 1'b0); push(8'hFF, 16'hD333, 1'b0);
    push(8'h00, 16'hD333, 1'b0); push(8'h01, 16'hD333, 1'b1);
    owner_bit = 4'b1000; gnt = 4'b1000;
    cycle();
    chk("t3_first_addr", 32'(bus_addr), 32'hFE);
    clr();
    run(5);
    chk("t3_done_cnt", 32'(done_cnt), 1);
    chk("t3_done_owner", 32'(done_acc), 32'h8);
    chk("t3_beats", 32'(pops), 4);
    gnt = 4'b0;
    run(2);

    // Master 0: maximum-length burst (16 beats) with wrap.
    set_m(0, 8'hF8, 4'd15);
    for (int i = 0; i < 16; i++) push(8'hF8 + 8'(i), 16'hA000, (i == 15));
    owner_bit = 4'b0001; gnt = 4'b0001;
    cycle();
    clr();
    run(17);
    chk("tmax_beats", 32'(pops), 16);
    chk("tmax_done", 32'(done_acc), 32'h1);
    chk("tmax_no_abort", 32'(abort_cnt), 0);
    gnt = 4'b0;
    run(2);

    // Master 2: grant withdrawn after two accepted beats.
    set_m(2, 8'h20, 4'd5);
    push(8'h20, 16'hC222, 1'b0); push(8'h21, 16'hC222, 1'b0);
    owner_bit = 4'b0100; gnt = 4'b0100;
    cycle();
    clr();
    run(2);
    chk("t4_third_offer", 32'(bus_addr), 32'h22);
    gnt = 4'b0;
    cycle();
    chk("t4_valid_dropped", 32'(bus_valid), 0);
    chk("t4_abort_pulse", 32'(abort), 32'h4);
    chk("t4_no_done", 32'(done), 0);
    run(3);
    chk("t4_abort_once", 32'(abort_cnt), 1);
    chk("t4_done_none", 32'(done_cnt), 0);
    chk("t4_beats", 32'(pops), 2);
    chk("t4_idle", 32'(busy), 0);

    // Illegal multi-bit grant is ignored.
    owner_bit = 4'b0;
    gnt = 4'b0011;
    clr();
    run(3);
    chk("t6_multi_busy", 32'(busy), 0);
    chk("t6_multi_valid", 32'(valid_cnt), 0);
    gnt = 4'b0;
    run(1);

    // Reset in the middle of a burst.
    set_m(0, 8'h10, 4'd2);
    push(8'h10, 16'hA000, 1'b0);
    owner_bit = 4'b0001; gnt = 4'b0001;
    cycle();
    run(1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_valid", 32'(bus_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_last", 32'(bus_last), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_abort", 32'(abort), 0);
    rst = 1'b0; gnt = 4'b0;
    clr();
    run(3);
    chk("t6_post_rst_done", 32'(done_cnt), 0);
    chk("t6_post_rst_abort", 32'(abort_cnt), 0);
    chk("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
